// File: rtl/cpu6502_pkg.sv
// Shared 6502 core definitions: status flag bit positions and reset value.
// Imported by the status register and any block that decodes P bits.
// No ports; constants only.
package cpu6502_pkg;

  // Bit positions inside the P register / pushed status byte.
  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  // I set, bits 5/4 read as 1, all other flags clear.
  localparam logic [7:0] P_RESET = 8'h34;

endpackage

// File: rtl/so_edge_detect.sv
// Falling-edge detector for an active-low, already-synchronous pin (SO, NMI).
// Ports: i_clk, i_reset_n (async low), i_sig_n (pin), o_fall (one-cycle pulse).
// History flop resets high so a pin already low at reset release fires once.
module so_edge_detect (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_sig_n,
  output logic o_fall
);

  logic prev_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) prev_q <= 1'b1;
    else            prev_q <= i_sig_n;
  end

  // High on the cycle the pin is seen low after being high.
  assign o_fall = prev_q & ~i_sig_n;

endmodule

// File: rtl/processor_status_register.sv
// 6502 processor status register (P) with per-flag load priority and SO sampling.
// Ports: i_clk, i_reset_n (async low); i_db/i_ir5/i_acr/i_avr data sources;
//   per-flag load strobes; i_so_n pin; i_irq_push selects B in the push view;
//   o_p status view {N,V,1,1,D,I,Z,C}; o_p_db push byte with B = ~i_irq_push.
module processor_status_register
  import cpu6502_pkg::*;
#(
  parameter logic [7:0] RESET_P = P_RESET
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [7:0] i_db,
  input  logic       i_ir5,
  input  logic       i_acr,
  input  logic       i_avr,
  input  logic       i_db0_c,
  input  logic       i_ir5_c,
  input  logic       i_acr_c,
  input  logic       i_db1_z,
  input  logic       i_dbz_z,
  input  logic       i_db2_i,
  input  logic       i_ir5_i,
  input  logic       i_1_i,
  input  logic       i_db3_d,
  input  logic       i_ir5_d,
  input  logic       i_db6_v,
  input  logic       i_avr_v,
  input  logic       i_0_v,
  input  logic       i_db7_n,
  input  logic       i_so_n,
  input  logic       i_irq_push,
  output logic [7:0] o_p,
  output logic [7:0] o_p_db
);

  logic c_q, z_q, i_q, d_q, v_q, n_q;
  logic so_fall;

  so_edge_detect u_so_edge (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_sig_n   (i_so_n),
    .o_fall    (so_fall)
  );

  // Bits 5 and 4 of RESET_P are not stored; they are rebuilt on the outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      c_q <= RESET_P[P_C];
      z_q <= RESET_P[P_Z];
      i_q <= RESET_P[P_I];
      d_q <= RESET_P[P_D];
      v_q <= RESET_P[P_V];
      n_q <= RESET_P[P_N];
    end else begin
      if      (i_db0_c) c_q <= i_db[P_C];
      else if (i_acr_c) c_q <= i_acr;
      else if (i_ir5_c) c_q <= i_ir5;

      if      (i_db1_z) z_q <= i_db[P_Z];
      else if (i_dbz_z) z_q <= (i_db == 8'h00);

      if      (i_1_i)   i_q <= 1'b1;
      else if (i_db2_i) i_q <= i_db[P_I];
      else if (i_ir5_i) i_q <= i_ir5;

      if      (i_db3_d) d_q <= i_db[P_D];
      else if (i_ir5_d) d_q <= i_ir5;

      // Any explicit V write swallows a coincident SO event; it is not replayed.
      if      (i_db6_v) v_q <= i_db[P_V];
      else if (i_avr_v) v_q <= i_avr;
      else if (i_0_v)   v_q <= 1'b0;
      else if (so_fall) v_q <= 1'b1;

      if (i_db7_n) n_q <= i_db[P_N];
    end
  end

  always_comb begin
    o_p      = 8'h00;
    o_p[P_C] = c_q;
    o_p[P_Z] = z_q;
    o_p[P_I] = i_q;
    o_p[P_D] = d_q;
    o_p[P_B] = 1'b1;
    o_p[P_U] = 1'b1;
    o_p[P_V] = v_q;
    o_p[P_N] = n_q;

    // Hardware interrupt pushes store B clear; PHP/BRK store it set.
    o_p_db      = o_p;
    o_p_db[P_B] = ~i_irq_push;
  end

endmodule
